// File: rtl/context_switch_ctrl_pkg.sv
// rtl/context_switch_ctrl_pkg.sv - shared types and context layout constants for the context-switch sequencer
package ctx_pkg;

    localparam int NUM_PROCS     = 4;
    localparam int PID_W         = $clog2(NUM_PROCS);
    localparam int WORD_BITS     = 32;
    localparam int CTX_WORDS     = 72;
    localparam int CTX_REG_WORDS = 64;
    localparam int DISP_WORDS    = CTX_WORDS - CTX_REG_WORDS;
    localparam int CTX_STRIDE    = 256;
    localparam int DISP_BITS     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SNAP,
        ST_WAIT_ACK,
        ST_SELECT,
        ST_LOAD,
        ST_RESTORE
    } ctx_state_t;

endpackage

// File: rtl/context_switch_ctrl_if.sv
// rtl/context_switch_ctrl_if.sv - scheduler/RAM-side signal bundle of the context-switch sequencer
interface context_switch_ctrl_if;
    import ctx_pkg::*;

    logic                                Enable;
    logic [NUM_PROCS-1:0]                Proc_Active;
    logic                                Halt;
    logic                                Update_PC;
    logic [CTX_WORDS*WORD_BITS-1:0]      Load_Data;

    logic                                Snapshot;
    logic [PID_W-1:0]                    Proc_ID;
    logic                                Stall;
    logic                                Restore;
    logic [CTX_REG_WORDS*WORD_BITS-1:0]  Restore_Regs;
    logic [DISP_WORDS*DISP_BITS-1:0]     Restore_Disp;
    logic                                Switch_Done;
    logic                                Ack_Error;
    logic [15:0]                         Switch_Count;

    modport master (
        output Enable, Proc_Active, Halt, Update_PC, Load_Data,
        input  Snapshot, Proc_ID, Stall, Restore, Restore_Regs, Restore_Disp,
               Switch_Done, Ack_Error, Switch_Count
    );

    modport slave (
        input  Enable, Proc_Active, Halt, Update_PC, Load_Data,
        output Snapshot, Proc_ID, Stall, Restore, Restore_Regs, Restore_Disp,
               Switch_Done, Ack_Error, Switch_Count
    );

endinterface

// File: rtl/context_switch_ctrl_rr.sv
// rtl/context_switch_ctrl_rr.sv - round-robin next-process picker; the current slot is considered last
module rr_next_proc
    import ctx_pkg::*;
#(
    parameter int N   = NUM_PROCS,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_mask,
    input  logic [IDW-1:0] i_cur_id,
    output logic [IDW-1:0] o_next_id,
    output logic           o_valid
);

    // Scan from the farthest offset down so the nearest live slot after the current one wins.
    always_comb begin
        o_next_id = i_cur_id;
        o_valid   = |i_mask;
        for (int off = N; off >= 1; off--) begin
            if (i_mask[(int'(i_cur_id) + off) % N]) begin
                o_next_id = IDW'((int'(i_cur_id) + off) % N);
            end
        end
    end

endmodule

// File: rtl/context_switch_ctrl.sv
// rtl/context_switch_ctrl.sv - preemptive save/select/restore sequencer in front of the context RAM
// Build option CTX_SWITCH_COUNT_EN adds a saturating count of completed switches.
module context_switch_ctrl
    import ctx_pkg::*;
#(
    parameter int QUANTUM     = 1024,
    parameter int QWIDTH      = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    context_switch_ctrl_if.slave   bus
);

    localparam int TOW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [QWIDTH-1:0] Q_LAST  = QWIDTH'(QUANTUM - 1);
    localparam logic [TOW-1:0]    TO_LAST = TOW'(ACK_TIMEOUT - 1);

    ctx_state_t                         r_state;
    logic [QWIDTH-1:0]                  r_q_cnt;
    logic [TOW-1:0]                     r_to_cnt;
    logic [PID_W-1:0]                   r_proc_id;
    logic                               r_snapshot;
    logic                               r_stall;
    logic                               r_restore;
    logic                               r_done;
    logic                               r_ack_error;
    logic [CTX_REG_WORDS*WORD_BITS-1:0] r_regs;
    logic [DISP_WORDS*DISP_BITS-1:0]    r_disp;

    logic [PID_W-1:0]                   w_next_id;
    logic                               w_next_valid;
    logic [CTX_STRIDE-1:0]              w_disp_region;
    logic [DISP_WORDS*DISP_BITS-1:0]    w_disp;
    logic [DISP_WORDS*(WORD_BITS-DISP_BITS)-1:0] w_unused_disp_hi;

    rr_next_proc #(.N(NUM_PROCS), .IDW(PID_W)) u_rr (
        .i_mask    (bus.Proc_Active),
        .i_cur_id  (r_proc_id),
        .o_next_id (w_next_id),
        .o_valid   (w_next_valid)
    );

    // Display latches only take the low segment bits of each display word.
    assign w_disp_region = bus.Load_Data[CTX_REG_WORDS*WORD_BITS +: CTX_STRIDE];

    always_comb begin
        w_disp           = '0;
        w_unused_disp_hi = '0;
        for (int k = 0; k < DISP_WORDS; k++) begin
            w_disp[k*DISP_BITS +: DISP_BITS] = w_disp_region[k*WORD_BITS +: DISP_BITS];
            w_unused_disp_hi[k*(WORD_BITS-DISP_BITS) +: (WORD_BITS-DISP_BITS)] =
                w_disp_region[k*WORD_BITS+DISP_BITS +: (WORD_BITS-DISP_BITS)];
        end
    end

    // Strobes are set on the transition into their state so every output leaves a flop.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_q_cnt     <= '0;
            r_to_cnt    <= '0;
            r_proc_id   <= '0;
            r_snapshot  <= 1'b0;
            r_stall     <= 1'b0;
            r_restore   <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_regs      <= '0;
            r_disp      <= '0;
        end else begin
            r_snapshot <= 1'b0;
            r_restore  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Enable) begin
                        r_state <= ST_RUN;
                        r_q_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.Enable) begin
                        r_state <= ST_IDLE;
                        r_q_cnt <= '0;
                    end else if (bus.Halt || (r_q_cnt == Q_LAST)) begin
                        r_state    <= ST_SNAP;
                        r_snapshot <= 1'b1;
                        r_stall    <= 1'b1;
                    end else begin
                        r_q_cnt <= r_q_cnt + 1'b1;
                    end
                end
                ST_SNAP: begin
                    r_state  <= ST_WAIT_ACK;
                    r_to_cnt <= '0;
                end
                ST_WAIT_ACK: begin
                    if (bus.Update_PC) begin
                        r_state <= ST_SELECT;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_ack_error <= 1'b1;
                        r_state     <= ST_SELECT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (w_next_valid) begin
                        r_proc_id <= w_next_id;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_regs    <= bus.Load_Data[CTX_REG_WORDS*WORD_BITS-1:0];
                    r_disp    <= w_disp;
                    r_restore <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= ST_RESTORE;
                end
                ST_RESTORE: begin
                    r_q_cnt <= '0;
                    r_stall <= 1'b0;
                    r_state <= bus.Enable ? ST_RUN : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CTX_SWITCH_COUNT_EN
    logic [15:0] r_switch_count;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_switch_count <= '0;
        end else if ((r_state == ST_RESTORE) && (r_switch_count != 16'hFFFF)) begin
            r_switch_count <= r_switch_count + 16'd1;
        end
    end

    assign bus.Switch_Count = r_switch_count;
`else
    assign bus.Switch_Count = '0;
`endif

    assign bus.Snapshot     = r_snapshot;
    assign bus.Proc_ID      = r_proc_id;
    assign bus.Stall        = r_stall;
    assign bus.Restore      = r_restore;
    assign bus.Switch_Done  = r_done;
    assign bus.Ack_Error    = r_ack_error;
    assign bus.Restore_Regs = r_regs;
    assign bus.Restore_Disp = r_disp;

endmodule

// File: tb/tb_context_switch_ctrl.sv
// tb/tb_context_switch_ctrl.sv - directed self-checking bench for context_switch_ctrl
module tb_context_switch_ctrl;
    import ctx_pkg::*;

`ifdef CTX_SWITCH_COUNT_EN
    localparam int EXP_CNT1 = 1;
    localparam int EXP_CNT8 = 8;
`else
    localparam int EXP_CNT1 = 0;
    localparam int EXP_CNT8 = 0;
`endif

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   n_snap;
    int   n_overlap;
    int   n;
    int   snap0;

    logic [CTX_WORDS*WORD_BITS-1:0] ctx_mem [NUM_PROCS];

    context_switch_ctrl_if bus();

    context_switch_ctrl #(.QUANTUM(8), .QWIDTH(16), .ACK_TIMEOUT(15)) dut (
        .Clock   (clk),
        .Reset_n (rstn),
        .bus     (bus)
    );

    // Behaves like the RAM read mux: context of whichever slot is selected.
    assign bus.Load_Data = ctx_mem[bus.Proc_ID];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.Snapshot) n_snap++;
        if ((bus.Snapshot && bus.Restore) || (bus.Restore != bus.Switch_Done)) n_overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input int budget, output int cnt);
        bit done;
        done = 1'b0;
        cnt  = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!done) begin
                step();
                if ((which == 0 && bus.Snapshot) || (which == 1 && bus.Restore) ||
                    (which == 2 && bus.Ack_Error)) begin
                    cnt  = i;
                    done = 1'b1;
                end
            end
        end
    endtask

    // Enter RUN, run extra_run more cycles, then Halt; ack in the first WAIT_ACK cycle.
    task automatic halt_switch(input string tag, input int extra_run);
        int lat;
        step();
        repeat (extra_run) step();
        bus.Halt = 1'b1;
        step();
        bus.Halt = 1'b0;
        chk({tag, "_snap"}, bus.Snapshot, 1);
        step();
        bus.Update_PC = 1'b1;
        step();
        bus.Update_PC = 1'b0;
        wait_sig(1, 10, lat);
        chk({tag, "_restore_lat"}, 64'(lat), 2);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_snap = 0; n_overlap = 0;
        for (int p = 0; p < NUM_PROCS; p++) begin
            for (int k = 0; k < CTX_WORDS; k++) begin
                ctx_mem[p][k*32 +: 32] = {8'(p), 8'(k), 16'hA5C3};
            end
        end
        ctx_mem[1][5*32 +: 32]  = 32'hDEADBEEF;
        ctx_mem[1][66*32 +: 32] = 32'h123456BF;

        rstn = 1'b0; bus.Enable = 1'b0; bus.Proc_Active = 4'b0011;
        bus.Halt = 1'b0; bus.Update_PC = 1'b0;
        step(); step();
        chk("rst_stall",   bus.Stall, 0);
        chk("rst_procid",  bus.Proc_ID, 0);
        chk("rst_ackerr",  bus.Ack_Error, 0);
        chk("rst_snap",    bus.Snapshot, 0);
        chk("rst_restore", bus.Restore, 0);
        chk("rst_count",   bus.Switch_Count, 0);
        chk("rst_regs",    bus.Restore_Regs[191:160], 0);

        // Quantum expiry: RUN entered 1 cycle after release, Snapshot 8 cycles later.
        rstn = 1'b1; bus.Enable = 1'b1;
        wait_sig(0, 20, n);
        chk("q_snap_lat", 64'(n), 9);
        chk("q_snap_stall", bus.Stall, 1);
        step();
        bus.Update_PC = 1'b1;
        step();
        bus.Update_PC = 1'b0;
        chk("q_procid_pre", bus.Proc_ID, 0);
        wait_sig(1, 10, n);
        chk("q_restore_lat", 64'(n), 2);
        chk("q_procid", bus.Proc_ID, 1);
        chk("q_done", bus.Switch_Done, 1);
        chk("q_stall_restore", bus.Stall, 1);
        chk("q_regs_w5", bus.Restore_Regs[191:160], 32'hDEADBEEF);
        chk("q_disp2", bus.Restore_Disp[20:14], 7'h3F);
        step();
        chk("q_restore_once", bus.Restore, 0);
        chk("q_stall_run", bus.Stall, 0);
        chk("q_count", bus.Switch_Count, EXP_CNT1);

        // Halt two cycles into RUN: slot 1 -> 0.
        halt_switch("halt", 1);
        chk("halt_procid", bus.Proc_ID, 0);
        chk("halt_regs_w5", bus.Restore_Regs[191:160], 32'h0005A5C3);
        chk("halt_disp2", bus.Restore_Disp[20:14], 7'h43);

        // Halt in the expiry cycle: one switch only.
        snap0 = n_snap;
        halt_switch("both", 7);
        chk("both_one_snap", 64'(n_snap - snap0), 1);
        chk("both_procid", bus.Proc_ID, 1);

        bus.Proc_Active = 4'b0100;
        halt_switch("to2", 0);
        chk("to2_procid", bus.Proc_ID, 2);
        halt_switch("lone", 0);
        chk("lone_procid", bus.Proc_ID, 2);
        bus.Proc_Active = 4'b1000;
        halt_switch("to3", 0);
        chk("to3_procid", bus.Proc_ID, 3);
        bus.Proc_Active = 4'b1010;
        halt_switch("wrap", 0);
        chk("wrap_procid", bus.Proc_ID, 1);

        // No acknowledge: error after 15 WAIT_ACK cycles, switch still completes.
        step();
        bus.Halt = 1'b1;
        step();
        bus.Halt = 1'b0;
        chk("to_snap", bus.Snapshot, 1);
        chk("to_err_pre", bus.Ack_Error, 0);
        wait_sig(2, 30, n);
        chk("to_err_lat", 64'(n), 16);
        wait_sig(1, 10, n);
        chk("to_restore_lat", 64'(n), 2);
        chk("to_procid", bus.Proc_ID, 3);
        repeat (4) step();
        chk("to_err_sticky", bus.Ack_Error, 1);
        chk("to_count", bus.Switch_Count, EXP_CNT8);

        // Reset in WAIT_ACK.
        bus.Halt = 1'b1;
        step();
        bus.Halt = 1'b0;
        step();
        rstn = 1'b0;
        step();
        chk("mid_rst_stall",  bus.Stall, 0);
        chk("mid_rst_procid", bus.Proc_ID, 0);
        chk("mid_rst_ackerr", bus.Ack_Error, 0);
        chk("mid_rst_count",  bus.Switch_Count, 0);
        chk("mid_rst_regs",   bus.Restore_Regs[191:160], 0);
        chk("mid_rst_disp",   bus.Restore_Disp, 0);

        // Enable low holds IDLE well past a quantum.
        rstn = 1'b1; bus.Enable = 1'b0;
        snap0 = n_snap;
        repeat (20) step();
        chk("idle_no_snap", 64'(n_snap - snap0), 0);
        chk("idle_stall", bus.Stall, 0);
        chk("no_overlap", 64'(n_overlap), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
